// File: rtl/apb_master_bridge_if.sv
// Request/response port plus APB bus signals of apb_master_bridge.
// master: bridge side; slave: requester and APB slaves side.
interface apb_master_bridge_if #(
  parameter int unsigned PDATA_SIZE = 32,
  parameter int unsigned NUM_SLAVES = 2
);
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_write;
  logic [31:0]                    req_addr;
  logic [PDATA_SIZE-1:0]          req_wdata;
  logic [PDATA_SIZE/8-1:0]        req_strb;
  logic                           rsp_valid;
  logic [PDATA_SIZE-1:0]          rsp_rdata;
  logic                           rsp_err;
  logic [NUM_SLAVES-1:0]          PSEL;
  logic                           PENABLE;
  logic [31:0]                    PADDR;
  logic                           PWRITE;
  logic [PDATA_SIZE/8-1:0]        PSTRB;
  logic [PDATA_SIZE-1:0]          PWDATA;
  logic [NUM_SLAVES*PDATA_SIZE-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]          PREADY;
  logic [NUM_SLAVES-1:0]          PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-beat valid/ready to APB requester with address-decoded slave select.
// Define APB_TIMEOUT_EN to bound ACCESS wait states to TIMEOUT_CYCLES.
module apb_master_bridge #(
  parameter int unsigned PDATA_SIZE     = 32,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned SEL_LSB        = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  localparam int unsigned StrbW = PDATA_SIZE / 8;
  // One code above the slave count always exists, so unmapped regions decode as errors.
  localparam int unsigned SelBits = $clog2(NUM_SLAVES + 1);
  localparam logic [31:0] SelMask = 32'(((64'd1 << SelBits) - 64'd1) << SEL_LSB);

  if ((PDATA_SIZE % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("apb_master_bridge: PDATA_SIZE must be a multiple of 8, TIMEOUT_CYCLES > 0");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [31:0]           paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [StrbW-1:0]      pstrb_q, pstrb_d;
  logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [PDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
`endif

  logic [SelBits-1:0]    req_idx;
  logic                  req_idx_ok;
  logic                  sel_ready;
  logic                  sel_err;
  logic [PDATA_SIZE-1:0] sel_rdata;

  assign req_idx    = bus.req_addr[SEL_LSB +: SelBits];
  assign req_idx_ok = 32'(req_idx) < NUM_SLAVES;

  // psel_q stays one-hot through ACCESS, so it doubles as the response mux select.
  always_comb begin
    sel_ready = |(bus.PREADY & psel_q);
    sel_err   = |(bus.PSLVERR & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_rdata = bus.PRDATA[i*PDATA_SIZE +: PDATA_SIZE];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_idx_ok) begin
            state_d  = StSetup;
            psel_d   = NUM_SLAVES'(1) << req_idx;
            paddr_d  = bus.req_addr & ~SelMask;
            pwrite_d = bus.req_write;
            pstrb_d  = bus.req_write ? bus.req_strb : '0;
            pwdata_d = bus.req_wdata;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      StAccess: begin
`ifdef APB_TIMEOUT_EN
        if (wait_cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          state_d     = StIdle;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (sel_ready) begin
          state_d     = StIdle;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`else
        if (sel_ready) begin
          state_d     = StIdle;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end
`endif
      end

      default: begin
        state_d   = StIdle;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PWDATA    = pwdata_q;

endmodule
